lzc_norm_pipe: RTL and testbench

//  Parametrised, pipelined leading-zero / leading-sign counter and normaliser for the

---
 rtl/lzc_norm_pipe.sv | 142 ++++++++++++++
 tb/tb_lzc_norm_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-zero / redundant-sign counter with normalising shift.
// S1 holds the word and its tree count; S2 holds the mode-adjusted count and the shifted word.
module lzc_norm_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_zero,
    output logic [DATA_WIDTH-1:0] out_norm
);

    localparam int LVLS = $clog2(DATA_WIDTH);

    logic                  w_s1_adv;
    logic                  w_s2_adv;
    logic [DATA_WIDTH-1:0] w_src;
    logic [CNT_W-1:0]      w_raw_cnt;
    logic                  w_in_zero;
    logic [CNT_W-1:0]      w_cnt;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_norm;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_mode;
    logic [CNT_W-1:0]      r_s1_cnt;
    logic                  r_s1_zero;

    assign w_s2_adv  = ~out_valid | out_ready;
    assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
    assign in_ready  = w_s1_adv;

    // Sign mode turns leading copies of the MSB into leading zeros.
    assign w_src     = in_data ^ {DATA_WIDTH{in_mode & in_data[DATA_WIDTH-1]}};
    assign w_in_zero = ~|in_data;

    // A node of width 2^k is all-zero exactly when its count has bit k set.
    for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
        localparam int NODES = DATA_WIDTH >> k;
        logic [NODES*CNT_W-1:0] w_lvl_cnt;
        for (genvar j = 0; j < NODES; j++) begin : g_node
            if (k == 0) begin : g_leaf
                assign w_lvl_cnt[j*CNT_W +: CNT_W] = {{(CNT_W-1){1'b0}}, ~w_src[j]};
            end else begin : g_join
                logic [CNT_W-1:0] w_hi_cnt;
                logic [CNT_W-1:0] w_lo_cnt;
                assign w_hi_cnt = g_lvl[k-1].w_lvl_cnt[(2*j+1)*CNT_W +: CNT_W];
                assign w_lo_cnt = g_lvl[k-1].w_lvl_cnt[(2*j)*CNT_W +: CNT_W];
                assign w_lvl_cnt[j*CNT_W +: CNT_W] =
                    w_hi_cnt[k-1] ? (w_hi_cnt + w_lo_cnt) : w_hi_cnt;
            end
        end
    end

    assign w_raw_cnt = g_lvl[LVLS].w_lvl_cnt[CNT_W-1:0];

    // Stage 1: capture word, mode, raw count and zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {DATA_WIDTH{1'b0}};
            r_s1_mode  <= 1'b0;
            r_s1_cnt   <= {CNT_W{1'b0}};
            r_s1_zero  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_mode <= in_mode;
                r_s1_cnt  <= w_raw_cnt;
                r_s1_zero <= w_in_zero;
            end else begin
                r_s1_data <= r_s1_data;
                r_s1_mode <= r_s1_mode;
                r_s1_cnt  <= r_s1_cnt;
                r_s1_zero <= r_s1_zero;
            end
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Sign-mode count excludes the sign bit itself; the raw count is always >= 1 there.
    always_comb begin
        w_cnt = r_s1_cnt;
        if (r_s1_mode) begin
            w_cnt = r_s1_cnt - CNT_W'(1);
        end else begin
            w_cnt = r_s1_cnt;
        end
    end

    // Log-stage barrel shifter; the top count bit only occurs for a full-width shift.
    always_comb begin
        w_shift = r_s1_data;
        w_norm  = {DATA_WIDTH{1'b0}};
        for (int b = 0; b < LVLS; b++) begin
            if (w_cnt[b]) begin
                w_shift = w_shift << (1 << b);
            end else begin
                w_shift = w_shift;
            end
        end
        if (w_cnt[LVLS]) begin
            w_norm = {DATA_WIDTH{1'b0}};
        end else begin
            w_norm = w_shift;
        end
    end

    // Stage 2: registered outputs, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= {CNT_W{1'b0}};
            out_zero  <= 1'b0;
            out_norm  <= {DATA_WIDTH{1'b0}};
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_count <= w_cnt;
                out_zero  <= r_s1_zero;
                out_norm  <= w_norm;
            end else begin
                out_count <= out_count;
                out_zero  <= out_zero;
                out_norm  <= out_norm;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe: three widths (8, 32, 128) driven in lockstep, scoreboard per width.
module tb_lzc_norm_pipe;

    typedef struct {
        logic [7:0]   cnt;
        logic         z;
        logic [127:0] n;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_mode;
    logic [127:0] in_data;
    logic         out_ready;

    logic         in_ready_8,  out_valid_8,  out_zero_8;
    logic         in_ready_32, out_valid_32, out_zero_32;
    logic         in_ready_128, out_valid_128, out_zero_128;
    logic [3:0]   out_count_8;
    logic [5:0]   out_count_32;
    logic [7:0]   out_count_128;
    logic [7:0]   out_norm_8;
    logic [31:0]  out_norm_32;
    logic [127:0] out_norm_128;

    exp_t q8[$];
    exp_t q32[$];
    exp_t q128[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_rel32 = 0;
    logic acc = 1'b0;

    lzc_norm_pipe #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_8),
        .in_data(in_data[7:0]), .in_mode(in_mode), .out_valid(out_valid_8),
        .out_ready(out_ready), .out_count(out_count_8), .out_zero(out_zero_8),
        .out_norm(out_norm_8)
    );

    lzc_norm_pipe #(.DATA_WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32),
        .in_data(in_data[31:0]), .in_mode(in_mode), .out_valid(out_valid_32),
        .out_ready(out_ready), .out_count(out_count_32), .out_zero(out_zero_32),
        .out_norm(out_norm_32)
    );

    lzc_norm_pipe #(.DATA_WIDTH(128)) u_dut128 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_128),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_128),
        .out_ready(out_ready), .out_count(out_count_128), .out_zero(out_zero_128),
        .out_norm(out_norm_128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-by-bit reference: walk down from the MSB while bits match the reference value.
    function automatic exp_t model(input logic [127:0] d, input logic m, input int w);
        exp_t         e;
        logic [127:0] x;
        logic [127:0] mask;
        logic         ref_b;
        int           lead;
        mask  = (w == 128) ? {128{1'b1}} : ((128'(1) << w) - 128'(1));
        x     = d & mask;
        ref_b = m ? x[w-1] : 1'b0;
        lead  = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (x[i] != ref_b) break;
            lead++;
        end
        e.cnt = m ? 8'(lead - 1) : 8'(lead);
        e.z   = (x == '0);
        e.n   = (int'(e.cnt) >= w) ? 128'(0) : ((x << e.cnt) & mask);
        return e;
    endfunction

    // One clock: sample at the falling edge, update scoreboards, return 1 ns after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q8.delete();
            q32.delete();
            q128.delete();
            acc = 1'b0;
        end else begin
            acc = in_valid && in_ready_32;
            n_vec++;
            if (in_ready_8 !== in_ready_32 || in_ready_128 !== in_ready_32) begin
                n_err++;
                $display("FAIL ready_agree: got %b/%b/%b, want all equal", in_ready_8, in_ready_32, in_ready_128);
            end
            if (out_valid_8 === 1'b1 && out_ready) begin
                n_vec++;
                if (q8.size() == 0) begin
                    n_err++;
                    $display("FAIL sb8_extra: got output %h, want none", out_norm_8);
                end else begin
                    e = q8.pop_front();
                    if ({out_count_8, out_zero_8, out_norm_8} !== {e.cnt[3:0], e.z, e.n[7:0]}) begin
                        n_err++;
                        $display("FAIL sb8: got cnt=%0d z=%b norm=%h, want cnt=%0d z=%b norm=%h",
                                 out_count_8, out_zero_8, out_norm_8, e.cnt, e.z, e.n[7:0]);
                    end
                end
            end
            if (out_valid_32 === 1'b1 && out_ready) begin
                n_vec++;
                n_rel32++;
                if (q32.size() == 0) begin
                    n_err++;
                    $display("FAIL sb32_extra: got output %h, want none", out_norm_32);
                end else begin
                    e = q32.pop_front();
                    if ({out_count_32, out_zero_32, out_norm_32} !== {e.cnt[5:0], e.z, e.n[31:0]}) begin
                        n_err++;
                        $display("FAIL sb32: got cnt=%0d z=%b norm=%h, want cnt=%0d z=%b norm=%h",
                                 out_count_32, out_zero_32, out_norm_32, e.cnt, e.z, e.n[31:0]);
                    end
                end
            end
            if (out_valid_128 === 1'b1 && out_ready) begin
                n_vec++;
                if (q128.size() == 0) begin
                    n_err++;
                    $display("FAIL sb128_extra: got output %h, want none", out_norm_128);
                end else begin
                    e = q128.pop_front();
                    if ({out_count_128, out_zero_128, out_norm_128} !== {e.cnt, e.z, e.n}) begin
                        n_err++;
                        $display("FAIL sb128: got cnt=%0d z=%b norm=%h, want cnt=%0d z=%b norm=%h",
                                 out_count_128, out_zero_128, out_norm_128, e.cnt, e.z, e.n);
                    end
                end
            end
            if (acc) begin
                q8.push_back(model(in_data, in_mode, 8));
                q32.push_back(model(in_data, in_mode, 32));
                q128.push_back(model(in_data, in_mode, 128));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({out_valid_32, out_count_32, out_zero_32, out_norm_32} !== 40'd0) begin
            n_err++;
            $display("FAIL reset_outs: got v=%b c=%0d z=%b n=%h, want all 0",
                     out_valid_32, out_count_32, out_zero_32, out_norm_32);
        end
        n_vec++;
        if (in_ready_32 !== 1'b1 || out_valid_8 !== 1'b0 || out_valid_128 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got rdy=%b v8=%b v128=%b, want 1 0 0", in_ready_32, out_valid_8, out_valid_128);
        end
    endtask

    task automatic test_mode0();
        out_ready = 1'b1; in_mode = 1'b0; in_valid = 1'b1;
        in_data = 128'h1;
        tick();
        n_vec++;
        if (out_valid_32 !== 1'b0) begin
            n_err++; $display("FAIL m0_latency: got out_valid=%b after 1 edge, want 0", out_valid_32);
        end
        in_data = 128'h8000_0000;
        tick();
        n_vec++;
        if ({out_valid_32, out_count_32, out_zero_32, out_norm_32} !== {1'b1, 6'd31, 1'b0, 32'h8000_0000}
            || out_count_128 !== 8'd127) begin
            n_err++;
            $display("FAIL m0_w1: got v=%b c=%0d z=%b n=%h c128=%0d, want 1 31 0 80000000 127",
                     out_valid_32, out_count_32, out_zero_32, out_norm_32, out_count_128);
        end
        in_data = 128'h0;
        tick();
        n_vec++;
        if ({out_count_32, out_zero_32, out_norm_32} !== {6'd0, 1'b0, 32'h8000_0000}
            || {out_count_8, out_zero_8, out_norm_8} !== {4'd8, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL m0_w2: got c=%0d z=%b n=%h c8=%0d z8=%b, want 0 0 80000000 8 1",
                     out_count_32, out_zero_32, out_norm_32, out_count_8, out_zero_8);
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if ({out_count_32, out_zero_32, out_norm_32} !== {6'd32, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL m0_w3: got c=%0d z=%b n=%h, want 32 1 0", out_count_32, out_zero_32, out_norm_32);
        end
        tick();
        n_vec++;
        if (out_valid_32 !== 1'b0) begin
            n_err++; $display("FAIL m0_bubble: got out_valid=%b, want 0", out_valid_32);
        end
    endtask

    task automatic test_mode1();
        out_ready = 1'b1; in_mode = 1'b1; in_valid = 1'b1;
        in_data = 128'hFFFF_FFF0;
        tick();
        in_data = 128'h0000_7FFF;
        tick();
        n_vec++;
        if ({out_count_32, out_zero_32, out_norm_32} !== {6'd27, 1'b0, 32'h8000_0000} || out_count_8 !== 4'd3) begin
            n_err++;
            $display("FAIL m1_w1: got c=%0d z=%b n=%h c8=%0d, want 27 0 80000000 3",
                     out_count_32, out_zero_32, out_norm_32, out_count_8);
        end
        in_data = 128'hFFFF_FFFF;
        tick();
        n_vec++;
        if ({out_count_32, out_zero_32, out_norm_32} !== {6'd16, 1'b0, 32'h7FFF_0000}) begin
            n_err++;
            $display("FAIL m1_w2: got c=%0d z=%b n=%h, want 16 0 7fff0000", out_count_32, out_zero_32, out_norm_32);
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if ({out_count_32, out_zero_32, out_norm_32} !== {6'd31, 1'b0, 32'h8000_0000}) begin
            n_err++;
            $display("FAIL m1_w3: got c=%0d z=%b n=%h, want 31 0 80000000", out_count_32, out_zero_32, out_norm_32);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          rel0 = n_rel32;
        logic [38:0] held = '0;
        in_mode = 1'b0;
        for (int cyc = 0; cyc < 40 && (sent < 8 || q32.size() != 0); cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            in_data   = 128'(sent + 1);
            #1;
            if (cyc >= 3 && cyc <= 6) begin
                n_vec++;
                if (in_ready_32 !== 1'b0) begin
                    n_err++; $display("FAIL b2b_ready: cycle %0d got in_ready=%b, want 0", cyc, in_ready_32);
                end
                if (cyc == 3) begin
                    held = {out_count_32, out_zero_32, out_norm_32};
                end else begin
                    n_vec++;
                    if ({out_count_32, out_zero_32, out_norm_32} !== held || out_valid_32 !== 1'b1) begin
                        n_err++;
                        $display("FAIL b2b_hold: cycle %0d got %h v=%b, want %h v=1", cyc,
                                 {out_count_32, out_zero_32, out_norm_32}, out_valid_32, held);
                    end
                end
            end
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (n_rel32 - rel0 != 8) begin
            n_err++; $display("FAIL b2b_count: got %0d words out, want 8", n_rel32 - rel0);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1; in_mode = 1'b0; in_valid = 1'b1;
        in_data = 128'h10;
        tick();
        in_data = 128'h20;
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({out_valid_32, out_count_32, out_zero_32, out_norm_32} !== 40'd0 || out_valid_128 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got v=%b c=%0d z=%b n=%h, want all 0",
                     out_valid_32, out_count_32, out_zero_32, out_norm_32);
        end
        in_valid = 1'b1; in_data = 128'h300;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid_32 !== 1'b0) begin
            n_err++; $display("FAIL rst_lat1: got out_valid=%b, want 0", out_valid_32);
        end
        tick();
        n_vec++;
        if ({out_valid_32, out_count_32, out_norm_32} !== {1'b1, 6'd22, 32'hC000_0000}) begin
            n_err++;
            $display("FAIL rst_next: got v=%b c=%0d n=%h, want 1 22 c0000000", out_valid_32, out_count_32, out_norm_32);
        end
        tick();
    endtask

    task automatic test_random(input int n_words);
        int           sent = 0;
        int           cyc  = 0;
        logic [127:0] r;
        int           sel;
        while (sent < n_words && cyc < 60000) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            r = r >> $urandom_range(0, 128);
            r[31:0] = $urandom >> $urandom_range(0, 32);
            r[7:0]  = 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) r = ~r;
            sel = $urandom_range(0, 15);
            if (sel == 0) r = '0;
            else if (sel == 1) r = '1;
            in_data   = r;
            in_mode   = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (acc) sent++;
            cyc++;
        end
        n_vec++;
        if (sent != n_words) begin
            n_err++; $display("FAIL rand_budget: got %0d words accepted, want %0d", sent, n_words);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && (q8.size() + q32.size() + q128.size()) != 0; i++) tick();
        n_vec++;
        if (q8.size() != 0 || q32.size() != 0 || q128.size() != 0) begin
            n_err++;
            $display("FAIL rand_drain: got %0d/%0d/%0d pending, want 0/0/0", q8.size(), q32.size(), q128.size());
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_back_to_back();
        test_reset_midstream();
        test_random(10000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
